// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_pkg (plus pcmux / rv32i_types)
// Description : Shared types for the rv32i fetch stage.
//               pcmux       - PC-mux select encoding used by execute to steer
//                             the next PC (alu_out means "redirect").
//               rv32i_types - fetch request state machine encoding.
//               if_fetch_unit_pkg - fetch-stage constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================

package pcmux;
  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    alu_out  = 2'b01,
    alu_mod2 = 2'b10
  } pcmux_sel_t;
endpackage : pcmux

package rv32i_types;
  // IDLE : nothing outstanding
  // REQ  : live request outstanding, its response is enqueued
  // DROP : request outstanding whose response belongs to an abandoned path
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b10
  } fetch_state_t;
endpackage : rv32i_types

package if_fetch_unit_pkg;
  // Byte distance between consecutive instructions.
  localparam int unsigned c_INSTR_BYTES = 4;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned fq_count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction
endpackage : if_fetch_unit_pkg

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Bundle of the fetch stage's external signals: redirect input
//               from execute, instruction-memory request/response, and the
//               valid/ready instruction channel toward decode.
//   pcmux_sel / pc_imm      : redirect select and target
//   imem_read / imem_address: memory request (held until imem_resp)
//   imem_resp / imem_rdata  : one-cycle response strobe and instruction
//   instr_valid/instr_ready : decode handshake on the fetch-queue head
//   instr_pc / instr_data   : head entry contents
//   fq_count                : fetch-queue occupancy
// Modports    : master = fetch unit, slave = surrounding pipeline/memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FQ_DEPTH = 4
);
  localparam int c_CW = fq_count_width(FQ_DEPTH);

  pcmux::pcmux_sel_t pcmux_sel;
  logic [XLEN-1:0]   pc_imm;
  logic              imem_read;
  logic [XLEN-1:0]   imem_address;
  logic              imem_resp;
  logic [XLEN-1:0]   imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [XLEN-1:0]   instr_pc;
  logic [XLEN-1:0]   instr_data;
  logic [c_CW-1:0]   fq_count;

  modport master (
    input  pcmux_sel, pc_imm, imem_resp, imem_rdata, instr_ready,
    output imem_read, imem_address, instr_valid, instr_pc, instr_data, fq_count
  );

  modport slave (
    output pcmux_sel, pc_imm, imem_resp, imem_rdata, instr_ready,
    input  imem_read, imem_address, instr_valid, instr_pc, instr_data, fq_count
  );
endinterface : if_fetch_unit_if

`default_nettype wire

// File: rtl/if_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO holding {pc, instruction} pairs.
//               Power-of-two depth so read/write pointers wrap naturally.
//               flush empties the queue and wins over push/pop that cycle.
//   clk, rst            : clock, asynchronous active-low reset
//   push, push_data     : enqueue request and payload
//   pop                 : dequeue head (ignored while empty)
//   flush               : discard all entries
//   head_data           : head entry, zero while empty
//   count               : occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   push,
  input  wire logic [WIDTH-1:0]       push_data,
  input  wire logic                   pop,
  input  wire logic                   flush,
  output logic      [WIDTH-1:0]       head_data,
  output logic      [$clog2(DEPTH):0] count
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_pop;

  assign w_do_pop = pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({push, w_do_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
endmodule : fetch_fifo

`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : rv32i instruction-fetch stage. Holds the fetch PC, keeps at
//               most one instruction-memory read outstanding, and queues the
//               returned {pc, instruction} pairs for decode. A taken control
//               transfer redirects the PC, flushes the queue and marks any
//               in-flight read as stale so its data is thrown away.
//   clk  : clock (rising edge)
//   rst  : asynchronous active-low reset
//   bus  : if_fetch_unit_if.master (redirect, imem, decode channel, fq_count)
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*, rv32i_types::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060,
  parameter int              FQ_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  if_fetch_unit_if.master bus
);
  localparam int              c_CW         = fq_count_width(FQ_DEPTH);
  localparam logic [c_CW-1:0] c_DEPTH      = c_CW'(FQ_DEPTH);
  localparam logic [XLEN-1:0] c_STEP       = XLEN'(c_INSTR_BYTES);
  localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(3);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_req_addr;
  logic [XLEN-1:0]   w_fetch_pc_plus4;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_load_addr;
  logic              w_load_req;
  logic              w_redirect;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_issue_ok;
  logic [c_CW-1:0]   w_fifo_count;
  logic [c_CW-1:0]   w_count_next;
  logic [2*XLEN-1:0] w_head;

  // --------------------------------------------------------------------------
  // Redirect, enqueue/dequeue qualification
  // --------------------------------------------------------------------------
  assign w_redirect       = (bus.pcmux_sel == pcmux::alu_out);
  assign w_target         = bus.pc_imm & ~c_ALIGN_MASK;
  assign w_fetch_pc_plus4 = r_fetch_pc + c_STEP;  // wraps modulo 2^XLEN
  assign w_valid          = (w_fifo_count != '0);

  // Only a live (non-stale) response that is not overtaken by a redirect
  // reaches the queue; a redirect also cancels any same-cycle dequeue.
  assign w_push = (r_state == REQ) && bus.imem_resp && !w_redirect;
  assign w_pop  = w_valid && bus.instr_ready && !w_redirect;

  // Occupancy after this cycle's pop and push; a new request is only
  // launched if its response is guaranteed a free slot.
  assign w_count_next = w_fifo_count - {{(c_CW-1){1'b0}}, w_pop}
                                     + {{(c_CW-1){1'b0}}, w_push};
  assign w_issue_ok   = (w_count_next < c_DEPTH);

  // --------------------------------------------------------------------------
  // Request FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_redirect && w_issue_ok) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (w_redirect) begin
          // Outstanding read still owed by memory -> wait it out in DROP.
          w_state_next = bus.imem_resp ? IDLE : DROP;
        end else if (bus.imem_resp) begin
          w_state_next = w_issue_ok ? REQ : IDLE;
        end
      end
      DROP: begin
        // A further redirect while dropping just keeps waiting; the stale
        // response always returns the FSM to IDLE.
        if (bus.imem_resp) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request FSM: outputs (Moore)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.imem_read = (r_state == REQ) || (r_state == DROP);
  end

  // Request address is loaded only when entering or staying in REQ for a new
  // read, so it never moves while a read (live or stale) is outstanding.
  always_comb begin
    w_load_req  = 1'b0;
    w_load_addr = r_fetch_pc;
    if (w_state_next == REQ) begin
      if (r_state == IDLE) begin
        w_load_req  = 1'b1;
        w_load_addr = r_fetch_pc;
      end else if (w_push) begin
        w_load_req  = 1'b1;
        w_load_addr = w_fetch_pc_plus4;
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC and request-address registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= w_target;
      end else if (w_push) begin
        r_fetch_pc <= w_fetch_pc_plus4;
      end
      if (w_load_req) begin
        r_req_addr <= w_load_addr;
      end
    end
  end

  assign bus.imem_address = r_req_addr;

  // --------------------------------------------------------------------------
  // Fetch queue
  // --------------------------------------------------------------------------
  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_req_addr, bus.imem_rdata}),
    .pop       (w_pop),
    .flush     (w_redirect),
    .head_data (w_head),
    .count     (w_fifo_count)
  );

  assign bus.instr_valid = w_valid;
  assign bus.instr_pc    = w_head[2*XLEN-1:XLEN];
  assign bus.instr_data  = w_head[XLEN-1:0];
  assign bus.fq_count    = w_fifo_count;
endmodule : if_fetch_unit

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit. A behavioural memory
//               answers each read one cycle after it is first seen; a
//               reference PC model and a scoreboard queue of expected
//               {pc, instruction} pairs track what decode must receive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;
  import pcmux::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0060;
  localparam int          FQ_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  if_fetch_unit_if #(.XLEN(XLEN), .FQ_DEPTH(FQ_DEPTH)) bus ();

  if_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] popped[$];
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] cur_addr = RESET_PC;
  bit          stale    = 1'b0;
  bit          prev_acc = 1'b0;
  bit          ready    = 1'b0;
  int          lat_cnt  = 0;
  int          n_acc    = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check current outputs, drive inputs, update the model,
  // advance to 1 time unit after the next rising edge.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit resp_ok);
    bit          resp;
    logic [63:0] e;
    if (prev_acc) chk("lat_valid", bus.instr_valid, 1);
    if (bus.imem_read) begin
      if (lat_cnt == 0 && !stale) begin
        chk("req_addr", bus.imem_address, model_pc);
        cur_addr = model_pc;
      end else begin
        chk("addr_hold", bus.imem_address, cur_addr);
      end
    end
    resp = bus.imem_read && resp_ok && (lat_cnt >= 1);
    bus.imem_resp   = resp;
    bus.imem_rdata  = resp ? mem_word(cur_addr) : 32'hDEAD_BEEF;
    bus.pcmux_sel   = redir ? alu_out : pc_plus4;
    bus.pc_imm      = tgt;
    bus.instr_ready = ready;
    prev_acc = 1'b0;
    if (redir) begin
      exp_q.delete();
      model_pc = tgt & 32'hFFFF_FFFC;
    end else begin
      if (bus.instr_valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_on_empty", bus.instr_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("head", {bus.instr_pc, bus.instr_data}, e);
          popped.push_back(bus.instr_pc);
        end
      end
      if (resp && !stale) begin
        exp_q.push_back({cur_addr, mem_word(cur_addr)});
        model_pc = cur_addr + 32'd4;
        prev_acc = 1'b1;
        n_acc++;
      end
    end
    if (resp) stale = 1'b0;
    else if (redir && bus.imem_read) stale = 1'b1;
    if (!bus.imem_read || resp) lat_cnt = 0;
    else lat_cnt++;
    @(posedge clk);
    #1;
    total++;
    assert (bus.fq_count <= 3'(FQ_DEPTH)) else begin
      bad++;
      $error("FAIL fq_overflow observed=%0d expected<=%0d", bus.fq_count, FQ_DEPTH);
    end
    chk("fq_count", bus.fq_count, exp_q.size());
  endtask

  // Advance at least one cycle, then until a fresh live request appears.
  task automatic wait_req(output logic [31:0] a);
    int n = 0;
    cycle(1'b0, 32'd0, 1'b1);
    while (!(bus.imem_read && lat_cnt == 0 && !stale) && n < 30) begin
      cycle(1'b0, 32'd0, 1'b1);
      n++;
    end
    total++;
    assert (n < 30) else begin
      bad++;
      $error("FAIL wait_req_timeout observed=%0d expected<30", n);
    end
    a = bus.imem_address;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.imem_resp = 1'b0;
    bus.pcmux_sel = pc_plus4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    stale    = 1'b0;
    lat_cnt  = 0;
    prev_acc = 1'b0;
    model_pc = RESET_PC;
    cur_addr = RESET_PC;
  endtask

  initial begin
    logic [31:0] a;
    int          idle_run;

    bus.pcmux_sel   = pc_plus4;
    bus.pc_imm      = '0;
    bus.imem_resp   = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_read", bus.imem_read, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_fq_count", bus.fq_count, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_instr_data", bus.instr_data, 0);
    chk("rst_imem_addr", bus.imem_address, RESET_PC);

    // Release and sequential fetch with decode always ready
    rst = 1'b1;
    chk("rel_no_read_yet", bus.imem_read, 0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("first_read", bus.imem_read, 1);
    chk("first_addr", bus.imem_address, 32'h60);
    ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 30 && popped.size() < 3; i++) cycle(1'b0, 32'd0, 1'b1);
    chk("seq_pc0", popped[0], 32'h60);
    chk("seq_pc1", popped[1], 32'h64);
    chk("seq_pc2", popped[2], 32'h68);

    // Back-pressure: queue fills to exactly FQ_DEPTH, then fetch stalls
    do_reset();
    ready    = 1'b0;
    n_acc    = 0;
    idle_run = 0;
    for (int i = 0; i < 60 && idle_run < 4; i++) begin
      cycle(1'b0, 32'd0, 1'b1);
      idle_run = bus.imem_read ? 0 : idle_run + 1;
    end
    chk("fill_accepted", n_acc, FQ_DEPTH);
    chk("fill_fq_count", bus.fq_count, FQ_DEPTH);
    chk("fill_read_low", bus.imem_read, 0);
    chk("fill_valid", bus.instr_valid, 1);
    ready = 1'b1;
    wait_req(a);
    chk("resume_addr", a, 32'h70);
    repeat (10) cycle(1'b0, 32'd0, 1'b1);

    // Redirect while a read is outstanding without response
    wait_req(a);
    cycle(1'b1, 32'h0000_1003, 1'b0);
    chk("drop_valid", bus.instr_valid, 0);
    chk("drop_fq_count", bus.fq_count, 0);
    chk("drop_read_held", bus.imem_read, 1);
    chk("drop_addr_held", bus.imem_address, cur_addr);
    repeat (3) cycle(1'b0, 32'd0, 1'b0);
    wait_req(a);
    chk("drop_target", a, 32'h0000_1000);

    // Redirect coincident with a live response and a ready decode
    ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() >= 2 && bus.imem_read && lat_cnt >= 1 && !stale) break;
      cycle(1'b0, 32'd0, 1'b1);
    end
    ready = 1'b1;
    chk("coin_pre_valid", bus.instr_valid, 1);
    chk("coin_pre_read", bus.imem_read, 1);
    cycle(1'b1, 32'h0000_1003, 1'b1);
    chk("coin_valid", bus.instr_valid, 0);
    chk("coin_fq_count", bus.fq_count, 0);
    chk("coin_idle", bus.imem_read, 0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("coin_req_n2", bus.imem_read, 1);
    chk("coin_addr_n2", bus.imem_address, 32'h0000_1000);

    // PC wrap at the top of the address space
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0);
    wait_req(a);
    chk("wrap_top", a, 32'hFFFF_FFFC);
    wait_req(a);
    chk("wrap_zero", a, 32'h0000_0000);

    // Asynchronous reset in the middle of a request
    rst = 1'b0;
    #1;
    chk("arst_read", bus.imem_read, 0);
    chk("arst_valid", bus.instr_valid, 0);
    chk("arst_fq_count", bus.fq_count, 0);
    chk("arst_instr_pc", bus.instr_pc, 0);
    chk("arst_addr", bus.imem_address, RESET_PC);
    do_reset();
    chk("arst_rel_read", bus.imem_read, 0);
    cycle(1'b0, 32'd0, 1'b1);
    chk("arst_refetch_read", bus.imem_read, 1);
    chk("arst_refetch_addr", bus.imem_address, 32'h60);
    repeat (8) cycle(1'b0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule : tb_if_fetch_unit

`default_nettype wire
